// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the CDB arbiter: broadcast payload, FU source codes and
// the ROB age comparison used by both the queues and the push path.
package cdb_arbiter_pkg;

  localparam int PREG_W    = 7;
  localparam int ROB_W     = 5;
  localparam int ROB_DEPTH = 16;
  localparam int AGE_W     = $clog2(ROB_DEPTH);

  typedef enum logic [1:0] {
    FU_NONE = 2'b00,
    FU_ALU  = 2'b01,
    FU_BR   = 2'b10,
    FU_MEM  = 2'b11
  } fu_e;

  typedef struct packed {
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_index;
    logic              has_dest;
    fu_e               fu;
  } cdb_data_t;

  // Distances are taken modulo ROB_DEPTH so the test survives ROB wrap-around.
  function automatic logic is_younger(input logic [ROB_W-1:0] x,
                                      input logic [ROB_W-1:0] tag,
                                      input logic [ROB_W-1:0] tail);
    logic [AGE_W-1:0] dx;
    logic [AGE_W-1:0] dt;
    dx = AGE_W'(x - tag);
    dt = AGE_W'(tail - tag);
    return (dx != '0) && (dx < dt);
  endfunction

endpackage

// File: rtl/cdb_queue.sv
// Per-FU result FIFO that collapses around entries killed by a mispredict,
// so the surviving head is always at index 0 and order is preserved.
module cdb_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  cdb_data_t        push_data,
  input  logic             pop,
  input  logic             flush,
  input  logic [ROB_W-1:0] flush_tag,
  input  logic [ROB_W-1:0] flush_tail,
  output logic             ready,
  output logic             head_valid,
  output cdb_data_t        head
);

  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  cdb_data_t        mem      [QDEPTH];
  cdb_data_t        mem_nxt  [QDEPTH];
  cdb_data_t        surv     [QDEPTH];
  int               surv_cnt;
  int               keep_cnt;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    surv_cnt = 0;
    for (int i = 0; i < QDEPTH; i++) surv[i] = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (i < int'(count) &&
          !(flush && is_younger(mem[i].rob_index, flush_tag, flush_tail))) begin
        surv[surv_cnt] = mem[i];
        surv_cnt++;
      end
    end
  end

  assign head       = surv[0];
  assign head_valid = (surv_cnt != 0);
  assign ready      = reset && (count < CNT_W'(QDEPTH));

  always_comb begin
    keep_cnt = surv_cnt - int'(pop);
    for (int j = 0; j < QDEPTH; j++)
      mem_nxt[j] = (j + int'(pop) < QDEPTH) ? surv[j + int'(pop)] : '0;
    if (push && keep_cnt < QDEPTH) begin
      mem_nxt[keep_cnt] = push_data;
      keep_cnt++;
    end
    count_nxt = CNT_W'(keep_cnt);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count <= '0;
    else        count <= count_nxt;
  end

  // NOTE: entry storage is deliberately not reset; count alone marks live entries.
  always_ff @(posedge clk) begin
    mem <= mem_nxt;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB slot between the ALU, branch
// and MEM result queues, with mispredict flushing of younger results.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [PREG_W-1:0] alu_pd,
  input  logic [ROB_W-1:0]  alu_rob,
  output logic              alu_ready,
  input  logic              b_valid,
  input  logic [PREG_W-1:0] b_pd,
  input  logic [ROB_W-1:0]  b_rob,
  output logic              b_ready,
  input  logic              mem_valid,
  input  logic [PREG_W-1:0] mem_pd,
  input  logic [ROB_W-1:0]  mem_rob,
  input  logic              mem_has_dest,
  output logic              mem_ready,
  input  logic              mispredict,
  input  logic [ROB_W-1:0]  mispredict_tag,
  input  logic [ROB_W-1:0]  rob_tail,
  output logic              cdb_valid,
  output logic [PREG_W-1:0] cdb_pd,
  output logic [ROB_W-1:0]  cdb_rob,
  output logic              cdb_has_dest,
  output logic [1:0]        cdb_fu
);

  localparam int NFU = 3;

  logic [NFU-1:0] in_valid;
  logic [NFU-1:0] push;
  logic [NFU-1:0] pop;
  logic [NFU-1:0] ready;
  logic [NFU-1:0] head_valid;
  cdb_data_t      in_data [NFU];
  cdb_data_t      head    [NFU];
  cdb_data_t      cdb_q;
  logic [1:0]     rr_ptr;
  logic [1:0]     rr_nxt;
  logic           grant_valid;
  int             grant_idx;

  assign in_valid = {mem_valid, b_valid, alu_valid};

  always_comb begin
    in_data[0] = '{pd: alu_pd, rob_index: alu_rob, has_dest: 1'b1,         fu: FU_ALU};
    in_data[1] = '{pd: b_pd,   rob_index: b_rob,   has_dest: 1'b0,         fu: FU_BR};
    in_data[2] = '{pd: mem_pd, rob_index: mem_rob, has_dest: mem_has_dest, fu: FU_MEM};
    for (int f = 0; f < NFU; f++)
      push[f] = in_valid[f] && ready[f] &&
                !(mispredict && is_younger(in_data[f].rob_index, mispredict_tag, rob_tail));
  end

  for (genvar g = 0; g < NFU; g++) begin : g_queue
    cdb_queue #(.QDEPTH(QDEPTH)) u_queue (
      .clk        (clk),
      .reset      (reset),
      .push       (push[g]),
      .push_data  (in_data[g]),
      .pop        (pop[g]),
      .flush      (mispredict),
      .flush_tag  (mispredict_tag),
      .flush_tail (rob_tail),
      .ready      (ready[g]),
      .head_valid (head_valid[g]),
      .head       (head[g])
    );
  end

  assign alu_ready = ready[0];
  assign b_ready   = ready[1];
  assign mem_ready = ready[2];

  // Heads seen here are already post-flush, so a killed head never wins.
  always_comb begin
    pop         = '0;
    grant_valid = 1'b0;
    grant_idx   = 0;
    rr_nxt      = rr_ptr;
    for (int k = 0; k < NFU; k++) begin
      if (!grant_valid && head_valid[(int'(rr_ptr) + k) % NFU]) begin
        grant_valid = 1'b1;
        grant_idx   = (int'(rr_ptr) + k) % NFU;
      end
    end
    if (grant_valid) begin
      pop[grant_idx] = 1'b1;
      rr_nxt         = 2'((grant_idx + 1) % NFU);
    end
  end

  // The slot is rewritten or invalidated every edge, so a flushed broadcast
  // can never repeat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cdb_valid <= 1'b0;
      cdb_q     <= '0;
      rr_ptr    <= 2'd0;
    end else begin
      cdb_valid <= grant_valid;
      rr_ptr    <= rr_nxt;
      if (grant_valid) cdb_q <= head[grant_idx];
    end
  end

  assign cdb_pd       = cdb_q.pd;
  assign cdb_rob      = cdb_q.rob_index;
  assign cdb_has_dest = cdb_q.has_dest;
  assign cdb_fu       = cdb_q.fu;

endmodule
